// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: IEEE-754 add/subtract, three register stages
// (align -> add/normalise -> round/pack) with valid/ready flow control.
// The S3 register is the output register, so the pipe holds at most three ops.
module fp_addsub_pipe #(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  parameter int W         = EXP_BITS + MANT_BITS + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sub,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   flags_out
);

  // Significand with hidden bit plus guard/round/sticky.
  localparam int SW = MANT_BITS + 4;
  // Exponent with one headroom bit for carry and rounding increments.
  localparam int EW = EXP_BITS + 1;

  localparam logic [EXP_BITS-1:0] EXP_MAX   = '1;
  localparam logic [EXP_BITS-1:0] EXP_ONE   = EXP_BITS'(1);
  localparam logic [EXP_BITS-1:0] SHIFT_LIM = EXP_BITS'(MANT_BITS + 3);
  localparam logic [EW-1:0]       EW_ONE    = EW'(1);
  localparam logic [W-1:0]        QNAN      = {1'b0, EXP_MAX, 1'b1, {(MANT_BITS-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Flow control: each stage loads when the stage after it is empty or moving.
  // ---------------------------------------------------------------------------
  logic s1_valid, s2_valid, s3_valid;
  logic en1, en2, en3;

  assign en3       = !s3_valid || out_ready;
  assign en2       = !s2_valid || en3;
  assign en1       = !s1_valid || en2;
  assign in_ready  = reset_n && en1;
  assign out_valid = s3_valid;

  // ---------------------------------------------------------------------------
  // S1: unpack, classify, order by magnitude, align the smaller operand
  // ---------------------------------------------------------------------------
  logic                 a_sign, b_sign;
  logic [EXP_BITS-1:0]  a_exp, b_exp;
  logic [MANT_BITS-1:0] a_frac, b_frac;
  logic                 a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  assign a_sign = in_a[W-1];
  assign b_sign = in_b[W-1] ^ in_sub;
  assign a_exp  = in_a[W-2:MANT_BITS];
  assign b_exp  = in_b[W-2:MANT_BITS];
  assign a_frac = in_a[MANT_BITS-1:0];
  assign b_frac = in_b[MANT_BITS-1:0];

  assign a_nan  = (a_exp == EXP_MAX) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_MAX) && (b_frac != '0);
  assign a_snan = a_nan && !a_frac[MANT_BITS-1];
  assign b_snan = b_nan && !b_frac[MANT_BITS-1];
  assign a_inf  = (a_exp == EXP_MAX) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_MAX) && (b_frac == '0);
  assign a_zero = (a_exp == '0) && (a_frac == '0);
  assign b_zero = (b_exp == '0) && (b_frac == '0);

  logic                 swap;
  logic                 big_sign, small_sign;
  logic [EXP_BITS-1:0]  big_exp, small_exp, big_eexp, small_eexp, exp_diff;
  logic [MANT_BITS-1:0] big_frac, small_frac;
  logic [SW-1:0]        big_man, small_man, small_al, lost;
  logic                 align_sticky;

  // Raw {exp,frac} ordering matches magnitude ordering, subnormals included.
  assign swap       = in_b[W-2:0] > in_a[W-2:0];
  assign big_sign   = swap ? b_sign : a_sign;
  assign small_sign = swap ? a_sign : b_sign;
  assign big_exp    = swap ? b_exp  : a_exp;
  assign small_exp  = swap ? a_exp  : b_exp;
  assign big_frac   = swap ? b_frac : a_frac;
  assign small_frac = swap ? a_frac : b_frac;

  assign big_eexp   = (big_exp == '0)   ? EXP_ONE : big_exp;
  assign small_eexp = (small_exp == '0) ? EXP_ONE : small_exp;
  assign exp_diff   = big_eexp - small_eexp;

  assign big_man   = {(big_exp != '0),   big_frac,   3'b000};
  assign small_man = {(small_exp != '0), small_frac, 3'b000};

  // Right shift of the smaller significand, lost bits folded into sticky.
  always_comb begin
    small_al     = '0;
    lost         = '0;
    align_sticky = 1'b0;
    if (exp_diff >= SHIFT_LIM) begin
      align_sticky = |small_man;
    end else begin
      small_al     = small_man >> exp_diff;
      lost         = small_man & ~({SW{1'b1}} << exp_diff);
      align_sticky = |lost;
    end
    small_al[0] = small_al[0] | align_sticky;
  end

  logic         sp_hit, sp_inv;
  logic [W-1:0] sp_val;

  // Special operands: the packed result is decided here and carried along.
  always_comb begin
    sp_hit = 1'b0;
    sp_inv = 1'b0;
    sp_val = '0;
    if (a_nan || b_nan) begin
      sp_hit = 1'b1;
      sp_val = QNAN;
      sp_inv = a_snan || b_snan;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      sp_hit = 1'b1;
      sp_val = QNAN;
      sp_inv = 1'b1;
    end else if (a_inf) begin
      sp_hit = 1'b1;
      sp_val = {a_sign, EXP_MAX, {MANT_BITS{1'b0}}};
    end else if (b_inf) begin
      sp_hit = 1'b1;
      sp_val = {b_sign, EXP_MAX, {MANT_BITS{1'b0}}};
    end else if (a_zero && b_zero) begin
      sp_hit = 1'b1;
      sp_val = {a_sign & b_sign, {(W-1){1'b0}}};
    end
  end

  logic                s1_sign, s1_sub, s1_sp, s1_sp_inv;
  logic [EXP_BITS-1:0] s1_exp;
  logic [SW-1:0]       s1_big, s1_small;
  logic [W-1:0]        s1_sp_val;

  // S1 register: captures operands only on the accepting edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= big_sign;
        s1_sub    <= big_sign ^ small_sign;
        s1_exp    <= big_eexp;
        s1_big    <= big_man;
        s1_small  <= small_al;
        s1_sp     <= sp_hit;
        s1_sp_inv <= sp_inv;
        s1_sp_val <= sp_val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: effective add/subtract and normalisation
  // ---------------------------------------------------------------------------
  function automatic logic [EW-1:0] lzc(input logic [SW-1:0] v);
    lzc = EW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) lzc = EW'(SW - 1 - i);
    end
  endfunction

  logic [SW:0]   sum;
  logic [EW-1:0] exp_w, lz, shamt, n_exp;
  logic [SW-1:0] n_man;
  logic          n_sign;

  assign exp_w = {1'b0, s1_exp};
  assign sum   = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});

  // Carry shifts right; otherwise shift left, never taking the exponent below 1.
  always_comb begin
    n_man  = '0;
    n_exp  = exp_w;
    n_sign = s1_sign;
    lz     = lzc(sum[SW-1:0]);
    shamt  = '0;
    if (sum[SW]) begin
      n_man    = sum[SW:1];
      n_man[0] = sum[1] | sum[0];
      n_exp    = exp_w + EW_ONE;
    end else begin
      shamt = (lz > (exp_w - EW_ONE)) ? (exp_w - EW_ONE) : lz;
      n_man = sum[SW-1:0] << shamt;
      n_exp = exp_w - shamt;
    end
    // Exact cancellation of nonzero operands yields +0.
    if (sum == '0) n_sign = 1'b0;
  end

  logic          s2_sign, s2_sp, s2_sp_inv;
  logic [EW-1:0] s2_exp;
  logic [SW-1:0] s2_man;
  logic [W-1:0]  s2_sp_val;

  // S2 register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign   <= n_sign;
        s2_exp    <= n_exp;
        s2_man    <= n_man;
        s2_sp     <= s1_sp;
        s2_sp_inv <= s1_sp_inv;
        s2_sp_val <= s1_sp_val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: round to nearest even, detect overflow/underflow, pack
  // ---------------------------------------------------------------------------
  logic [MANT_BITS:0]   sig, fsig;
  logic [MANT_BITS+1:0] rsum;
  logic [EW-1:0]        fexp;
  logic                 g_bit, r_bit, s_bit, rnd_up, inexact, hidden;
  logic [W-1:0]         r_data;
  logic [3:0]           r_flags;

  assign sig     = s2_man[SW-1:3];
  assign g_bit   = s2_man[2];
  assign r_bit   = s2_man[1];
  assign s_bit   = s2_man[0];
  assign inexact = g_bit | r_bit | s_bit;
  assign rnd_up  = g_bit & (r_bit | s_bit | sig[0]);
  assign rsum    = {1'b0, sig} + {{(MANT_BITS+1){1'b0}}, rnd_up};

  // Rounding carry renormalises; a subnormal rounding up into bit MANT_BITS
  // becomes the smallest normal without any extra handling.
  always_comb begin
    fsig    = rsum[MANT_BITS:0];
    fexp    = s2_exp;
    r_data  = '0;
    r_flags = '0;
    if (rsum[MANT_BITS+1]) begin
      fsig = rsum[MANT_BITS+1:1];
      fexp = s2_exp + EW_ONE;
    end
    hidden = fsig[MANT_BITS];
    if (s2_sp) begin
      r_data  = s2_sp_val;
      r_flags = {s2_sp_inv, 3'b000};
    end else if (hidden && (fexp >= {1'b0, EXP_MAX})) begin
      r_data  = {s2_sign, EXP_MAX, {MANT_BITS{1'b0}}};
      r_flags = 4'b0101;
    end else begin
      r_data  = {s2_sign, (hidden ? fexp[EXP_BITS-1:0] : {EXP_BITS{1'b0}}),
                 fsig[MANT_BITS-1:0]};
      r_flags = {1'b0, 1'b0, (!hidden && inexact), inexact};
    end
  end

  // Output register: holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s3_valid  <= 1'b0;
      data_out  <= '0;
      flags_out <= '0;
    end else if (en3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        data_out  <= r_data;
        flags_out <= r_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision vector table,
// stall/capacity stream, mid-flight reset and a half-precision instance.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, data_out;
  logic [3:0]  flags_out;

  logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_data_out;
  logic [3:0]  h_flags_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_BITS(8), .MANT_BITS(23)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .flags_out(flags_out)
  );

  fp_addsub_pipe #(.EXP_BITS(5), .MANT_BITS(10)) dut_h (
    .clk(clk), .reset_n(reset_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_sub(h_in_sub),
    .in_a(h_in_a), .in_b(h_in_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .data_out(h_data_out), .flags_out(h_flags_out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t        vecs[20];
  logic [31:0] sa[6], sb[6], se[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One op through an otherwise idle pipe; lat counts edges from the
  // accepting edge (lat=1) until out_valid is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] d, output logic [3:0] f, output int lat);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    d = data_out;
    f = flags_out;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  f;
    int          lat;
    int          idx_in, idx_out, last_x;
    logic        acc, xfer;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0}; // 1+2
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0}; // 1-1
    vecs[2]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'h0}; // subnormals
    vecs[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8}; // inf-inf
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5}; // overflow
    vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1}; // tie to even
    vecs[6]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1}; // tie up
    vecs[7]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8}; // sNaN
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0}; // qNaN
    vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0}; // -0 + -0
    vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'h0}; // +0 - +0
    vecs[11] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0}; // -0 - +0
    vecs[12] = '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'h0}; // inf - 1
    vecs[13] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0}; // 1 - inf
    vecs[14] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8}; // inf - inf
    vecs[15] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0}; // 1-2
    vecs[16] = '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'h0}; // normal->subnormal
    vecs[17] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'h1}; // sticky only
    vecs[18] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'h0}; // 1-2^-24 exact
    vecs[19] = '{32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 4'h1}; // 1-2^-25 tie

    sa[0] = 32'h3F800000; sb[0] = 32'h3F800000; se[0] = 32'h40000000; // 1+1
    sa[1] = 32'h3F800000; sb[1] = 32'h40000000; se[1] = 32'h40400000; // 1+2
    sa[2] = 32'h40000000; sb[2] = 32'h40000000; se[2] = 32'h40800000; // 2+2
    sa[3] = 32'h40400000; sb[3] = 32'h40000000; se[3] = 32'h40A00000; // 3+2
    sa[4] = 32'h40000000; sb[4] = 32'h40800000; se[4] = 32'h40C00000; // 2+4
    sa[5] = 32'h40800000; sb[5] = 32'h40800000; se[5] = 32'h41000000; // 4+4

    reset_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    h_in_valid = 1'b0; h_in_sub = 1'b0; h_in_a = '0; h_in_b = '0; h_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_flags", flags_out, 0);
    check("rst_in_ready", in_ready, 0);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, d, f, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].res);
      check($sformatf("vec%0d_flags", i), f, vecs[i].flg);
      if (i == 0) check("vec0_latency", lat, 3);
    end

    // Stream of 6 with the consumer stalled for the first 5 cycles
    idx_in = 0; idx_out = 0; last_x = -1;
    in_sub = 1'b0;
    for (int cyc = 0; cyc < 60 && idx_out < 6; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx_in < 6);
      if (idx_in < 6) begin in_a = sa[idx_in]; in_b = sb[idx_in]; end
      #2;
      if (cyc == 3) begin
        check("stall_valid_c3", out_valid, 1);
        check("stall_data_c3", data_out, se[0]);
      end
      if (cyc == 4) begin
        check("cap_accepts", idx_in, 3);
        check("cap_in_ready", in_ready, 0);
        check("stall_data_c4", data_out, se[0]);
        check("stall_flags_c4", flags_out, 0);
      end
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (xfer) begin
        check($sformatf("stream%0d_data", idx_out), data_out, se[idx_out]);
        if (idx_out > 0) check($sformatf("stream%0d_gap", idx_out), cyc - last_x, 1);
        last_x = cyc;
      end
      @(posedge clk); #1;
      if (acc)  idx_in++;
      if (xfer) idx_out++;
    end
    in_valid = 1'b0;
    check("stream_count", idx_out, 6);
    @(posedge clk); #1;

    // Reset with two ops in flight
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0;
    @(posedge clk); #1;
    in_a = 32'h7F800000; in_b = 32'hFF800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_flags", flags_out, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("no_stale_%0d", k), out_valid, 0);
    end
    run_op(32'h3F800000, 32'h40000000, 1'b0, d, f, lat);
    check("post_rst_data", d, 32'h40400000);
    check("post_rst_flags", f, 0);
    check("post_rst_latency", lat, 3);

    // Half precision: 1.0 + 2.0 = 3.0
    h_in_a = 16'h3C00; h_in_b = 16'h4000; h_in_sub = 1'b0; h_in_valid = 1'b1;
    #1;
    check("half_in_ready", h_in_ready, 1);
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("half_latency", lat, 3);
    check("half_data", h_data_out, 16'h4200);
    check("half_flags", h_flags_out, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
